// File: rtl/intersection_controller_pkg.sv
// Shared state codes, lamp encodings and phase
// duration lookup for the intersection controller.
package intersection_controller_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5
    } state_e;

    // One-hot {G,Y,R}
    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    function automatic int unsigned dur_m1(
        input state_e      s,
        input int unsigned min_green,
        input int unsigned yellow,
        input int unsigned all_red,
        input int unsigned side_green
    );
        case (s)
            MAIN_GREEN:               return min_green - 1;
            MAIN_YELLOW, SIDE_YELLOW: return yellow - 1;
            ALL_RED_A, ALL_RED_B:     return all_red - 1;
            SIDE_GREEN:               return side_green - 1;
            default:                  return min_green - 1;
        endcase
    endfunction

endpackage

// File: rtl/intersection_controller_timer.sv
// Loadable down-counter that saturates at zero
// and flags expiry.
module phase_timer #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= RESET_VALUE;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-road junction scheduler: main road rests on green,
// side road is served on request after minimum green.
module intersection_controller
    import intersection_controller_pkg::*;
#(
    parameter int MIN_GREEN       = 8,
    parameter int YELLOW_TIME     = 3,
    parameter int ALL_RED_TIME    = 2,
    parameter int SIDE_GREEN_TIME = 6,
    parameter int TIMER_WIDTH     = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Car_Side,
    output logic       Main_Green,
    output logic       Main_Yellow,
    output logic       Main_Red,
    output logic       Side_Green,
    output logic       Side_Yellow,
    output logic       Side_Red,
    output logic [2:0] Phase,
    output logic       Side_Pending
);

    localparam int MAX_DUR_A = (MIN_GREEN > YELLOW_TIME) ? MIN_GREEN : YELLOW_TIME;
    localparam int MAX_DUR_B = (ALL_RED_TIME > SIDE_GREEN_TIME) ? ALL_RED_TIME : SIDE_GREEN_TIME;
    localparam int MAX_DUR   = (MAX_DUR_A > MAX_DUR_B) ? MAX_DUR_A : MAX_DUR_B;

    if (MIN_GREEN < 1 || YELLOW_TIME < 1 || ALL_RED_TIME < 1 ||
        SIDE_GREEN_TIME < 1 || TIMER_WIDTH < 1 || TIMER_WIDTH > 30 ||
        (MAX_DUR - 1) > ((1 << TIMER_WIDTH) - 1)) begin : g_bad_params
        $error("intersection_controller: duration does not fit timer");
    end

    state_e                 state_q;
    state_e                 state_d;
    logic                   load;
    logic                   expired;
    logic [TIMER_WIDTH-1:0] load_value;
    logic                   side_pending_q;
    logic [2:0]             main_lamp;
    logic [2:0]             side_lamp;

    phase_timer #(
        .WIDTH      (TIMER_WIDTH),
        .RESET_VALUE(TIMER_WIDTH'(MIN_GREEN - 1))
    ) u_timer (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (load),
        .load_value(load_value),
        .expired   (expired)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= MAIN_GREEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN_GREEN:  if (expired && (side_pending_q || Car_Side)) state_d = MAIN_YELLOW;
            MAIN_YELLOW: if (expired) state_d = ALL_RED_A;
            ALL_RED_A:   if (expired) state_d = SIDE_GREEN;
            SIDE_GREEN:  if (expired) state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (expired) state_d = ALL_RED_B;
            ALL_RED_B:   if (expired) state_d = MAIN_GREEN;
            default:     state_d = MAIN_GREEN;
        endcase
        load       = (state_d != state_q);
        load_value = TIMER_WIDTH'(dur_m1(state_d, MIN_GREEN, YELLOW_TIME,
                                         ALL_RED_TIME, SIDE_GREEN_TIME));
    end

    // Entering side green serves the request, so clearing wins over a new car.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            side_pending_q <= 1'b0;
        end else if (state_d == SIDE_GREEN && state_q != SIDE_GREEN) begin
            side_pending_q <= 1'b0;
        end else if (Car_Side && state_q != SIDE_GREEN) begin
            side_pending_q <= 1'b1;
        end
    end

    always_comb begin
        main_lamp = LAMP_R;
        side_lamp = LAMP_R;
        case (state_q)
            MAIN_GREEN:  main_lamp = LAMP_G;
            MAIN_YELLOW: main_lamp = LAMP_Y;
            SIDE_GREEN:  side_lamp = LAMP_G;
            SIDE_YELLOW: side_lamp = LAMP_Y;
            default: ;
        endcase
    end

    assign {Main_Green, Main_Yellow, Main_Red} = main_lamp;
    assign {Side_Green, Side_Yellow, Side_Red} = side_lamp;
    assign Phase        = state_q;
    assign Side_Pending = side_pending_q;

    a_main_onehot: assert property (@(posedge Clock) disable iff (Reset)
        $onehot({Main_Green, Main_Yellow, Main_Red}));
    a_side_onehot: assert property (@(posedge Clock) disable iff (Reset)
        $onehot({Side_Green, Side_Yellow, Side_Red}));
    a_no_conflict: assert property (@(posedge Clock) disable iff (Reset)
        !((Main_Green || Main_Yellow) && (Side_Green || Side_Yellow)));
    a_main_g2y: assert property (@(posedge Clock) disable iff (Reset)
        $fell(Main_Green) && !$past(Reset) |-> Main_Yellow);
    a_main_y2r: assert property (@(posedge Clock) disable iff (Reset)
        $fell(Main_Yellow) && !$past(Reset) |-> Main_Red && Side_Red);
    a_side_g2y: assert property (@(posedge Clock) disable iff (Reset)
        $fell(Side_Green) && !$past(Reset) |-> Side_Yellow);
    a_side_y2r: assert property (@(posedge Clock) disable iff (Reset)
        $fell(Side_Yellow) && !$past(Reset) |-> Main_Red && Side_Red);

endmodule
